// File: rtl/therm_peak_hold.sv
// Thermometer-code receiver: decodes the sampled code to a 0..9 level, tracks a
// peak marker with timed hold and stepwise decay, and registers the LED drive.
module therm_peak_hold #(
  parameter int HOLD_CNT  = 12_500_000,
  parameter int DECAY_CNT = 2_500_000,
  parameter int CNT_W     = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] therm,
  input  logic       smpl,
  output logic [3:0] level,
  output logic [3:0] peak,
  output logic [8:0] led,
  output logic       therm_err
);

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] DECAY_LD = CNT_W'(DECAY_CNT - 1);

  typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] dec_q, dec_d;
  logic [3:0]       peak_q, peak_d;
  logic [3:0]       level_q, level_d;
  logic [8:0]       led_q, led_d;
  logic             err_q, err_d;
  logic [3:0]       lvl;
  logic             malformed;
  logic             capture;

  // Length of the run of ones starting at bit0.
  function automatic logic [3:0] therm_lvl(input logic [8:0] t);
    logic [3:0] l;
    l = 4'd9;
    for (int i = 8; i >= 0; i--) begin
      if (!t[i]) l = 4'(i);
    end
    return l;
  endfunction

  function automatic logic [8:0] led_map(input logic [3:0] lv, input logic [3:0] pk);
    logic [8:0] m;
    for (int i = 0; i < 9; i++) begin
      m[i] = (4'(i) < lv) || ((pk != 4'd0) && (4'(i) == pk - 4'd1));
    end
    return m;
  endfunction

  always_comb begin
    lvl       = therm_lvl(therm);
    malformed = (therm >> lvl) != 9'd0;
    capture   = smpl && (lvl != 4'd0) && (lvl >= peak_q);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dec_d   = dec_q;
    peak_d  = peak_q;
    if (capture) begin
      peak_d  = lvl;
      hold_d  = HOLD_LD;
      state_d = HOLD;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_q == '0) begin
            dec_d   = DECAY_LD;
            state_d = DECAY;
          end else begin
            hold_d = hold_q - CNT_W'(1);
          end
        end
        DECAY: begin
          if (dec_q == '0) begin
            peak_d = peak_q - 4'd1;
            if (peak_q == 4'd1) begin
              dec_d   = '0;
              state_d = IDLE;
            end else begin
              dec_d = DECAY_LD;
            end
          end else begin
            dec_d = dec_q - CNT_W'(1);
          end
        end
        default: begin
          peak_d = 4'd0;
        end
      endcase
    end
    level_d = smpl ? lvl : level_q;
    err_d   = smpl && malformed;
    // LED is built from next-state values so it lands together with level/peak.
    led_d   = led_map(level_d, peak_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      dec_q   <= '0;
      peak_q  <= 4'd0;
      level_q <= 4'd0;
      led_q   <= 9'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dec_q   <= dec_d;
      peak_q  <= peak_d;
      level_q <= level_d;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  assign level     = level_q;
  assign peak      = peak_q;
  assign led       = led_q;
  assign therm_err = err_q;

endmodule

// File: tb/tb_therm_peak_hold.sv
// Bench for therm_peak_hold with short hold/decay periods; directed scenarios
// plus random traffic checked against an elapsed-time reference model.
module tb_therm_peak_hold;
  localparam int HOLD  = 8;
  localparam int DECAY = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] therm;
  logic       smpl;
  logic [3:0] level;
  logic [3:0] peak;
  logic [8:0] led;
  logic       therm_err;

  int total = 0;
  int bad   = 0;

  // Model: peak is derived from the captured level and cycles since capture.
  int         m_cap   = 0;
  int         m_age   = 0;
  logic [3:0] m_level = 4'd0;
  logic       m_err   = 1'b0;

  therm_peak_hold #(.HOLD_CNT(HOLD), .DECAY_CNT(DECAY), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .therm(therm), .smpl(smpl),
    .level(level), .peak(peak), .led(led), .therm_err(therm_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_peak();
    int p;
    if (m_cap == 0) return 4'd0;
    if (m_age < HOLD) return 4'(m_cap);
    p = m_cap - (m_age - HOLD) / DECAY;
    if (p < 0) p = 0;
    return 4'(p);
  endfunction

  function automatic logic [8:0] m_led();
    logic [8:0] m;
    logic [3:0] pk;
    pk = m_peak();
    for (int i = 0; i < 9; i++)
      m[i] = (i < int'(m_level)) || (pk != 0 && i == int'(pk) - 1);
    return m;
  endfunction

  task automatic step(input logic s, input logic [8:0] t, input logic r);
    int         l;
    logic [3:0] cur;
    smpl = s; therm = t; rst = r;
    @(posedge clk);
    cur = m_peak();
    if (r) begin
      m_cap = 0; m_age = 0; m_level = 4'd0; m_err = 1'b0;
    end else begin
      l = 0;
      while (l < 9 && t[l]) l++;
      m_err = s && ((t >> l) != 9'd0);
      if (s) m_level = 4'(l);
      if (s && l > 0 && l >= int'(cur)) begin
        m_cap = l; m_age = 0;
      end else if (m_age < 100000) begin
        m_age++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 9'h0, 1); step(0, 9'h0, 1);
    total++; if ({level, peak, led, therm_err} !== 18'd0) begin bad++;
      $display("FAIL reset_init got=%h want=0", {level, peak, led, therm_err}); end
    step(1, 9'h01F, 0);
    for (int i = 0; i < 9; i++) step(0, 9'h0, 0);
    total++; if (peak !== 4'd5) begin bad++;
      $display("FAIL reset_pre_peak got=%0d want=5", peak); end
    for (int i = 0; i < 3; i++) step(1, 9'h1FF, 1);
    total++; if (level !== 4'd0 || peak !== 4'd0 || led !== 9'h000 || therm_err !== 1'b0) begin bad++;
      $display("FAIL reset_mid_decay got=%0d/%0d/%h/%b want=0/0/000/0", level, peak, led, therm_err); end
    for (int i = 0; i < 30; i++) begin
      step(0, 9'h0, 0);
      total++; if (peak !== 4'd0 || led !== 9'h000) begin bad++;
        $display("FAIL reset_idle peak=%0d led=%h want=0/000", peak, led); end
    end
    // Fresh capture must see a full hold period.
    step(1, 9'h007, 0);
    for (int i = 0; i < 11; i++) step(0, 9'h0, 0);
    total++; if (peak !== 4'd3) begin bad++;
      $display("FAIL reset_hold_end got=%0d want=3", peak); end
    step(0, 9'h0, 0);
    total++; if (peak !== 4'd2) begin bad++;
      $display("FAIL reset_first_dec got=%0d want=2", peak); end
  endtask

  task automatic test_decode_led();
    step(0, 9'h0, 1);
    step(1, 9'h01F, 0);
    total++; if (level !== 4'd5 || peak !== 4'd5 || led !== 9'h01F) begin bad++;
      $display("FAIL decode_5 got=%0d/%0d/%h want=5/5/01F", level, peak, led); end
    step(1, 9'h003, 0);
    total++; if (level !== 4'd2 || peak !== 4'd5 || led !== 9'h013) begin bad++;
      $display("FAIL decode_2 got=%0d/%0d/%h want=2/5/013", level, peak, led); end
    step(0, 9'h1FF, 0);
    total++; if (level !== 4'd2) begin bad++;
      $display("FAIL decode_nosmpl level got=%0d want=2", level); end
  endtask

  task automatic test_hold_decay();
    step(0, 9'h0, 1);
    step(1, 9'h01F, 0);
    step(1, 9'h000, 0);
    total++; if (level !== 4'd0 || peak !== 4'd5 || led !== 9'h010) begin bad++;
      $display("FAIL hd_dot got=%0d/%0d/%h want=0/5/010", level, peak, led); end
    for (int e = 2; e <= 32; e++) begin
      step(0, 9'h0, 0);
      total++; if (peak !== m_peak() || led !== m_led()) begin bad++;
        $display("FAIL hd_e%0d peak=%0d led=%h want=%0d/%h", e, peak, led, m_peak(), m_led()); end
      if (e == 11) begin total++; if (peak !== 4'd5) begin bad++;
        $display("FAIL hd_hold_last got=%0d want=5", peak); end end
      if (e == 12) begin total++; if (peak !== 4'd4 || led !== 9'h008) begin bad++;
        $display("FAIL hd_first_dec got=%0d/%h want=4/008", peak, led); end end
      if (e == 27) begin total++; if (peak !== 4'd1) begin bad++;
        $display("FAIL hd_last1 got=%0d want=1", peak); end end
      if (e == 28) begin total++; if (peak !== 4'd0 || led !== 9'h000) begin bad++;
        $display("FAIL hd_idle got=%0d/%h want=0/000", peak, led); end end
    end
  endtask

  task automatic test_rearm();
    step(0, 9'h0, 1);
    step(1, 9'h01F, 0);
    for (int i = 0; i < 19; i++) step(0, 9'h0, 0);
    total++; if (peak !== 4'd3) begin bad++;
      $display("FAIL rearm_pre got=%0d want=3", peak); end
    step(1, 9'h007, 0);
    total++; if (peak !== 4'd3) begin bad++;
      $display("FAIL rearm_tc got=%0d want=3", peak); end
    for (int i = 0; i < 11; i++) step(0, 9'h0, 0);
    total++; if (peak !== 4'd3) begin bad++;
      $display("FAIL rearm_hold got=%0d want=3", peak); end
    step(0, 9'h0, 0);
    total++; if (peak !== 4'd2) begin bad++;
      $display("FAIL rearm_dec got=%0d want=2", peak); end
    step(1, 9'h001, 0);
    total++; if (peak !== 4'd2 || level !== 4'd1) begin bad++;
      $display("FAIL rearm_lower got=%0d/%0d want=2/1", peak, level); end
  endtask

  task automatic test_malformed();
    step(0, 9'h0, 1);
    step(1, 9'h105, 0);
    total++; if (therm_err !== 1'b1 || level !== 4'd1 || peak !== 4'd1) begin bad++;
      $display("FAIL mal_105 got=%b/%0d/%0d want=1/1/1", therm_err, level, peak); end
    step(0, 9'h105, 0);
    total++; if (therm_err !== 1'b0) begin bad++;
      $display("FAIL mal_pulse got=%b want=0", therm_err); end
    step(1, 9'h1FF, 0);
    total++; if (level !== 4'd9 || led !== 9'h1FF || therm_err !== 1'b0 || peak !== 4'd9) begin bad++;
      $display("FAIL mal_1ff got=%0d/%h/%b/%0d want=9/1FF/0/9", level, led, therm_err, peak); end
  endtask

  task automatic test_zero();
    step(0, 9'h0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 9'h000, 0);
      total++; if (level !== 4'd0 || peak !== 4'd0 || led !== 9'h000 || therm_err !== 1'b0) begin bad++;
        $display("FAIL zero_%0d got=%0d/%0d/%h/%b want=0/0/000/0", i, level, peak, led, therm_err); end
    end
  endtask

  task automatic test_random();
    logic [8:0] t;
    logic       s;
    step(0, 9'h0, 1);
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) t = 9'($urandom);
      else t = 9'((1 << $urandom_range(0, 9)) - 1);
      step(s, t, 0);
      total++; if (level !== m_level || peak !== m_peak() || led !== m_led() || therm_err !== m_err) begin bad++;
        $display("FAIL rand_%0d got=%0d/%0d/%h/%b want=%0d/%0d/%h/%b", i, level, peak, led, therm_err,
                 m_level, m_peak(), m_led(), m_err); end
    end
  endtask

  initial begin
    rst = 1'b1; smpl = 1'b0; therm = 9'h0;
    test_reset();
    test_decode_led();
    test_hold_decay();
    test_rearm();
    test_malformed();
    test_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
